// File: rtl/lstm_seq_pkg.sv
// Shared types and sizing helpers for the LSTM sample sequencer.
package lstm_seq_pkg;

    // Sequencer control states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        DRAIN  = 3'd3,
        CLEAR  = 3'd4
    } seq_state_e;

    // Default fixed-point format: sign + integer + fractional bits.
    localparam int QN_DEF   = 6;
    localparam int QM_DEF   = 11;

    // Word width of a fixed-point value with qn integer and qm fractional bits.
    function automatic int bitwidth_f(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

    localparam int BITWIDTH = bitwidth_f(QN_DEF, QM_DEF);

    // Index width able to number n items (at least one bit).
    function automatic int idx_width_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lstm_vec_serializer.sv
// Turns a captured HIDDEN_SZ-word vector into a valid/ready word stream
// with neuron index and an end-of-sequence marker on the final word.
module lstm_vec_serializer
    import lstm_seq_pkg::*;
#(
    parameter int HIDDEN_SZ = 8,
    parameter int BW        = 18,
    localparam int IDX_W    = idx_width_f(HIDDEN_SZ)
)(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [HIDDEN_SZ*BW-1:0] load_vec,
    input  logic                    eos,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BW-1:0]           out_data,
    output logic [IDX_W-1:0]        out_index,
    output logic                    out_last,
    output logic                    done
);

    logic [HIDDEN_SZ*BW-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    done_s;

    // Load, shift-on-handshake and index/last bookkeeping.
    always_comb begin
        buf_d   = buf_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_s  = 1'b0;
        if (load) begin
            buf_d   = load_vec;
            idx_d   = '0;
            valid_d = 1'b1;
            last_d  = eos && (HIDDEN_SZ == 1);
        end else if (valid_q && out_ready) begin
            // The current word always sits in the low slot, so the output is a plain register.
            buf_d = buf_q >> BW;
            if (idx_q == IDX_W'(HIDDEN_SZ - 1)) begin
                valid_d = 1'b0;
                idx_d   = '0;
                last_d  = 1'b0;
                done_s  = 1'b1;
            end else begin
                idx_d  = idx_q + IDX_W'(1);
                last_d = eos && (idx_q == IDX_W'(HIDDEN_SZ - 2));
            end
        end else begin
            buf_d = buf_q;
        end
    end

    // Serializer state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = buf_q[BW-1:0];
    assign out_index = idx_q;
    assign out_last  = last_q;
    assign done      = done_s;

endmodule

// File: rtl/lstm_sample_sequencer.sv
// Feeds samples to the LSTM network, waits for its result, streams the
// hidden vector out word by word and clears recurrent state between sequences.
// Optional watchdog in WAIT enabled by defining LSTM_SEQ_TIMEOUT_EN.
module lstm_sample_sequencer
    import lstm_seq_pkg::*;
#(
    parameter int INPUT_SZ    = 2,
    parameter int HIDDEN_SZ   = 8,
    parameter int QN          = 6,
    parameter int QM          = 11,
    parameter int MAX_SEQ_LEN = 16,
    parameter int TIMEOUT_CYC = 1024,
    localparam int BW         = bitwidth_f(QN, QM),
    localparam int IDX_W      = idx_width_f(HIDDEN_SZ),
    localparam int SEQ_W      = $clog2(MAX_SEQ_LEN + 1)
)(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INPUT_SZ*BW-1:0]     in_data,
    input  logic                       in_last,
    output logic [INPUT_SZ*BW-1:0]     net_input,
    output logic                       net_newSample,
    output logic                       net_clearState,
    input  logic                       net_dataReady,
    input  logic [HIDDEN_SZ*BW-1:0]    net_outputVec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BW-1:0]              out_data,
    output logic [IDX_W-1:0]           out_index,
    output logic                       out_last,
    output logic [SEQ_W-1:0]           seq_count,
    output logic                       timeout_err
);

    seq_state_e               state_q, state_d;
    logic [INPUT_SZ*BW-1:0]   net_input_q, net_input_d;
    logic                     last_q, last_d;
    logic [SEQ_W-1:0]         seq_count_q, seq_count_d;
    logic                     in_ready_q, in_ready_d;
    logic                     new_sample_q, new_sample_d;
    logic                     clear_q, clear_d;
    logic                     dr_prev_q;
    logic                     dr_rise_s;
    logic                     load_s;
    logic                     eos_s;
    logic                     ser_done_s;

`ifdef LSTM_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic                     timeout_err_q, timeout_err_d;
`endif

    // Only a low-to-high transition of dataReady counts as a new result.
    assign dr_rise_s = net_dataReady && !dr_prev_q;
    // Sequence ends on a flagged last sample or when the length cap is hit.
    assign eos_s     = last_q || (seq_count_q == SEQ_W'(MAX_SEQ_LEN));

    // Next-state, sample capture and registered-output decode.
    always_comb begin
        state_d     = state_q;
        net_input_d = net_input_q;
        last_d      = last_q;
        seq_count_d = seq_count_q;
        load_s      = 1'b0;
`ifdef LSTM_SEQ_TIMEOUT_EN
        tmo_cnt_d     = '0;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    net_input_d = in_data;
                    last_d      = in_last;
                    seq_count_d = seq_count_q + SEQ_W'(1);
                    state_d     = LAUNCH;
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (dr_rise_s) begin
                    load_s  = 1'b1;
                    state_d = DRAIN;
                end
`ifdef LSTM_SEQ_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    // Give up on the sample: no beats, just clear recurrent state.
                    timeout_err_d = 1'b1;
                    state_d       = CLEAR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`else
                else begin
                    state_d = WAIT;
                end
`endif
            end
            DRAIN: begin
                if (ser_done_s) begin
                    state_d = eos_s ? CLEAR : IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            CLEAR: begin
                seq_count_d = '0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d   = (state_d == IDLE);
        new_sample_d = (state_d == LAUNCH);
        clear_d      = (state_d == CLEAR);
    end

    // Control and output registers; reset abandons any sample in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            net_input_q  <= '0;
            last_q       <= 1'b0;
            seq_count_q  <= '0;
            in_ready_q   <= 1'b0;
            new_sample_q <= 1'b0;
            clear_q      <= 1'b0;
            dr_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            net_input_q  <= net_input_d;
            last_q       <= last_d;
            seq_count_q  <= seq_count_d;
            in_ready_q   <= in_ready_d;
            new_sample_q <= new_sample_d;
            clear_q      <= clear_d;
            dr_prev_q    <= net_dataReady;
        end
    end

`ifdef LSTM_SEQ_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    lstm_vec_serializer #(
        .HIDDEN_SZ (HIDDEN_SZ),
        .BW        (BW)
    ) u_ser (
        .clock     (clock),
        .reset     (reset),
        .load      (load_s),
        .load_vec  (net_outputVec),
        .eos       (eos_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .done      (ser_done_s)
    );

    assign in_ready       = in_ready_q;
    assign net_input      = net_input_q;
    assign net_newSample  = new_sample_q;
    assign net_clearState = clear_q;
    assign seq_count      = seq_count_q;

endmodule

// File: tb/tb_lstm_sample_sequencer.sv
// Directed, table-driven bench for lstm_sample_sequencer (MAX_SEQ_LEN=4, TIMEOUT_CYC=32).
module tb_lstm_sample_sequencer;

    localparam int BW = 18;
    localparam int HS = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2*BW-1:0]   in_data = '0;
    logic              in_last = 1'b0;
    logic [2*BW-1:0]   net_input;
    logic              net_newSample;
    logic              net_clearState;
    logic              net_dataReady = 1'b0;
    logic [HS*BW-1:0]  net_outputVec = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [BW-1:0]     out_data;
    logic [2:0]        out_index;
    logic              out_last;
    logic [2:0]        seq_count;
    logic              timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    lstm_sample_sequencer #(
        .MAX_SEQ_LEN (4),
        .TIMEOUT_CYC (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .net_input      (net_input),
        .net_newSample  (net_newSample),
        .net_clearState (net_clearState),
        .net_dataReady  (net_dataReady),
        .net_outputVec  (net_outputVec),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_index      (out_index),
        .out_last       (out_last),
        .seq_count      (seq_count),
        .timeout_err    (timeout_err)
    );

    typedef struct {
        logic [BW-1:0] e0;
        logic [BW-1:0] e1;
        logic          last;
        int            dly;
        logic          toggle;
        logic          pre_high;
        logic [2:0]    exp_seq;
        logic          exp_eos;
    } rec_t;

    rec_t recs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [BW-1:0] word_f(input int s, input int k);
        return BW'(((s + 1) << 13) ^ (k << 9) ^ (k * 19 + s * 5 + 3));
    endfunction

    function automatic logic [HS*BW-1:0] vec_f(input int s);
        logic [HS*BW-1:0] v;
        v = '0;
        for (int k = 0; k < HS; k++) v[k*BW +: BW] = word_f(s, k);
        return v;
    endfunction

    task automatic check_zero_outputs();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_net_input", net_input, 0);
        chk("rst_newSample", net_newSample, 0);
        chk("rst_clearState", net_clearState, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_seq_count", seq_count, 0);
        chk("rst_timeout_err", timeout_err, 0);
    endtask

    task automatic do_reset();
        logic pulse_seen;
        reset = 1'b0;
        in_valid = 1'b0;
        net_dataReady = 1'b0;
        out_ready = 1'b0;
        #1;
        check_zero_outputs();
        repeat (2) step();
        check_zero_outputs();
        reset = 1'b1;
        step();
        chk("in_ready_after_release", in_ready, 1);
        pulse_seen = net_newSample | net_clearState;
        repeat (3) begin
            step();
            pulse_seen = pulse_seen | net_newSample | net_clearState;
        end
        chk("no_pulse_after_release", pulse_seen, 0);
    endtask

    task automatic run_rec(input rec_t r, input int s);
        int guard;
        int beat;
        int vcyc;
        logic phase;
        logic rdy;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        chk("in_ready_before_accept", in_ready, 1);
        if (r.pre_high) net_dataReady = 1'b1;
        in_valid = 1'b1;
        in_data  = {r.e1, r.e0};
        in_last  = r.last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = ~{r.e1, r.e0};
        chk("newSample_on", net_newSample, 1);
        chk("net_input", net_input, {r.e1, r.e0});
        chk("seq_count_accept", seq_count, r.exp_seq);
        chk("in_ready_busy", in_ready, 0);
        step();
        chk("newSample_single", net_newSample, 0);
        chk("net_input_held", net_input, {r.e1, r.e0});
        if (r.pre_high) begin
            vcyc = 0;
            repeat (5) begin
                step();
                if (out_valid) vcyc++;
            end
            chk("no_drain_on_high_level", vcyc, 0);
            net_dataReady = 1'b0;
            step();
        end
        repeat (r.dly) step();
        net_outputVec = vec_f(s);
        net_dataReady = 1'b1;
        step();
        net_outputVec = ~vec_f(s);
        net_dataReady = 1'b0;
        chk("out_valid_after_capture", out_valid, 1);
        beat  = 0;
        vcyc  = 0;
        phase = 1'b0;
        guard = 0;
        while (beat < HS && guard < 64) begin
            if (out_valid) begin
                vcyc++;
                rdy = r.toggle ? phase : 1'b1;
                phase = ~phase;
                out_ready = rdy;
                if (rdy) begin
                    chk("beat_data", out_data, word_f(s, beat));
                    chk("beat_index", out_index, beat);
                    chk("beat_last", out_last, (beat == HS - 1) && r.exp_eos);
                    beat++;
                end
            end else begin
                out_ready = 1'b0;
            end
            step();
            guard++;
        end
        out_ready = 1'b0;
        chk("beats_delivered", beat, HS);
        chk("drain_cycles", vcyc, r.toggle ? 2 * HS : HS);
        chk("out_valid_done", out_valid, 0);
        chk("net_input_until_drain_exit", net_input, {r.e1, r.e0});
        if (r.exp_eos) begin
            chk("clearState_on", net_clearState, 1);
            chk("in_ready_in_clear", in_ready, 0);
            step();
            chk("clearState_single", net_clearState, 0);
            chk("seq_count_cleared", seq_count, 0);
            chk("in_ready_after_clear", in_ready, 1);
        end else begin
            chk("no_clearState", net_clearState, 0);
            chk("in_ready_back_to_back", in_ready, 1);
            chk("seq_count_kept", seq_count, r.exp_seq);
        end
    endtask

    initial begin
        int n;
        logic saw;
        logic saw_rdy;

        recs[0] = '{18'h00800, 18'h3F800, 1'b0, 9, 1'b0, 1'b0, 3'd1, 1'b0};
        recs[1] = '{18'h1ABCD, 18'h00001, 1'b0, 3, 1'b1, 1'b0, 3'd2, 1'b0};
        recs[2] = '{18'h3FFFF, 18'h20000, 1'b1, 0, 1'b0, 1'b0, 3'd3, 1'b1};
        recs[3] = '{18'h12345, 18'h2468A, 1'b0, 1, 1'b0, 1'b0, 3'd1, 1'b0};
        recs[4] = '{18'h0F0F0, 18'h30303, 1'b0, 2, 1'b1, 1'b0, 3'd2, 1'b0};
        recs[5] = '{18'h00000, 18'h3FFFF, 1'b0, 0, 1'b0, 1'b0, 3'd3, 1'b0};
        recs[6] = '{18'h15555, 18'h2AAAA, 1'b0, 4, 1'b0, 1'b0, 3'd4, 1'b1};
        recs[7] = '{18'h00042, 18'h10024, 1'b1, 0, 1'b0, 1'b1, 3'd1, 1'b1};

        do_reset();

        for (int i = 0; i < 8; i++) run_rec(recs[i], i);

        // Result never arrives: watchdog (if built in) or indefinite wait.
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        in_valid = 1'b1;
        in_data  = 36'h0_1234_5678;
        step();
        in_valid = 1'b0;
        chk("stall_newSample", net_newSample, 1);
        saw = 1'b0;
`ifdef LSTM_SEQ_TIMEOUT_EN
        n = 0;
        while (timeout_err !== 1'b1 && n < 60) begin
            step();
            n++;
            saw = saw | out_valid;
        end
        chk("timeout_cycle", n, 33);
        chk("timeout_no_out_valid", saw, 0);
        chk("timeout_clearState", net_clearState, 1);
        step();
        chk("timeout_in_ready_back", in_ready, 1);
        chk("timeout_seq_cleared", seq_count, 0);
        chk("timeout_sticky", timeout_err, 1);
        step();
        chk("timeout_sticky2", timeout_err, 1);
        // Put a sample into WAIT for the mid-operation reset below.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
`else
        saw_rdy = 1'b0;
        repeat (60) begin
            step();
            saw = saw | out_valid | net_clearState;
            saw_rdy = saw_rdy | in_ready | timeout_err;
        end
        chk("wait_forever_no_output", saw, 0);
        chk("wait_forever_not_ready", saw_rdy, 0);
        chk("wait_seq_count", seq_count, 1);
`endif

        // Mid-operation reset abandons the sample.
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
